// File: rtl/move_seq_unit_pkg.sv
// Shared encodings for the move/swap/sign-fill unit and its REP MOVS sequencer.
package move_seq_unit_pkg;

    localparam logic [2:0] MSQ_MOVE = 3'd0;
    localparam logic [2:0] MSQ_SWAP = 3'd1;
    localparam logic [2:0] MSQ_FILL = 3'd2;
    localparam logic [2:0] MSQ_SEXT = 3'd3;
    localparam logic [2:0] MSQ_ZEXT = 3'd4;
    localparam logic [2:0] MSQ_REP  = 3'd5;

    localparam logic [1:0] MSQ_SZ_BYTE  = 2'd0;
    localparam logic [1:0] MSQ_SZ_WORD  = 2'd1;
    localparam logic [1:0] MSQ_SZ_DWORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_REP  = 2'd2
    } msq_state_t;

    // size 3 is treated as dword, so the stride exponent saturates at 2
    function automatic logic [1:0] stride_log2(input logic [1:0] size);
        case (size)
            MSQ_SZ_BYTE: return 2'd0;
            MSQ_SZ_WORD: return 2'd1;
            default:     return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/move_seq_unit_ext.sv
// Combinational MOVE/SWAP/FILL/SEXT/ZEXT datapath; the top registers its result.
module move_seq_ext
    import move_seq_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       mode,
    input  logic [1:0]       size,
    input  logic [WIDTH-1:0] opnd0,
    input  logic [WIDTH-1:0] opnd1,
    output logic [WIDTH-1:0] res0,
    output logic [WIDTH-1:0] res1
);

    logic [WIDTH-1:0] low_mask;
    logic             sign;

    // Dword sources cover bits 31:0; with WIDTH=32 that makes SEXT/ZEXT a plain move
    always_comb begin
        case (size)
            MSQ_SZ_BYTE: begin
                low_mask = WIDTH'(8'hFF);
                sign     = opnd1[7];
            end
            MSQ_SZ_WORD: begin
                low_mask = WIDTH'(16'hFFFF);
                sign     = opnd1[15];
            end
            default: begin
                low_mask = WIDTH'(32'hFFFF_FFFF);
                sign     = opnd1[31];
            end
        endcase
    end

    always_comb begin
        res1 = opnd1;
        case (mode)
            MSQ_SWAP: begin
                res0 = opnd1;
                res1 = opnd0;
            end
            MSQ_FILL: res0 = (opnd0 & ~low_mask) | ({WIDTH{sign}} & low_mask);
            MSQ_SEXT: res0 = (opnd1 & low_mask) | ({WIDTH{sign}} & ~low_mask);
            MSQ_ZEXT: res0 = opnd1 & low_mask;
            default:  res0 = opnd1;
        endcase
    end

endmodule

// File: rtl/move_seq_unit.sv
// Registered, handshaked move/swap/sign-fill unit with a REP MOVS pointer sequencer.
module move_seq_unit
    import move_seq_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       mode,
    input  logic [1:0]       size,
    input  logic             dir,
    input  logic [CNT_W-1:0] rep_count,
    input  logic [WIDTH-1:0] opnd0_r,
    input  logic [WIDTH-1:0] opnd1_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] opnd0_w,
    output logic [WIDTH-1:0] opnd1_w,
    output logic             out_last,
    output logic             out_nop
);

    msq_state_t              state;
    logic [CNT_W-1:0]        cnt_p1;
    logic signed [WIDTH-1:0] step_p1;
    logic signed [WIDTH-1:0] stride_p0;
    logic signed [WIDTH-1:0] step_p0;
    logic [WIDTH-1:0]        ext0_p0;
    logic [WIDTH-1:0]        ext1_p0;
    logic                    accept;
    logic                    retire;
    logic                    is_rep;

    move_seq_ext #(
        .WIDTH(WIDTH)
    ) u_ext (
        .mode (mode),
        .size (size),
        .opnd0(opnd0_r),
        .opnd1(opnd1_r),
        .res0 (ext0_p0),
        .res1 (ext1_p0)
    );

    assign in_ready = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
    assign accept   = in_valid && in_ready;
    assign retire   = out_valid && out_ready;
    assign is_rep   = (mode == MSQ_REP);

    // Direction is folded into a signed step so the stepper is a single add
    always_comb begin
        stride_p0 = WIDTH'(1) << stride_log2(size);
        step_p0   = dir ? -stride_p0 : stride_p0;
    end

    // ---- stage p1: output register and sequencer state ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_nop   <= 1'b0;
            opnd0_w   <= '0;
            opnd1_w   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (accept) begin
                        out_valid <= 1'b1;
                        if (is_rep) begin
                            state    <= ST_REP;
                            opnd0_w  <= opnd0_r;
                            opnd1_w  <= opnd1_r;
                            out_nop  <= (rep_count == '0);
                            out_last <= (rep_count == '0) || (rep_count == CNT_W'(1));
                        end else begin
                            state    <= ST_HOLD;
                            opnd0_w  <= ext0_p0;
                            opnd1_w  <= ext1_p0;
                            out_nop  <= 1'b0;
                            out_last <= 1'b1;
                        end
                    end else if (retire) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                ST_REP: begin
                    if (retire) begin
                        if (out_last) begin
                            state     <= ST_IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_nop   <= 1'b0;
                        end else begin
                            opnd0_w  <= opnd0_w + $unsigned(step_p1);
                            opnd1_w  <= opnd1_w + $unsigned(step_p1);
                            out_last <= (cnt_p1 == CNT_W'(1));
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // cnt_p1 holds the beats still to come after the one currently presented
    always_ff @(posedge clk) begin
        if (accept && is_rep) begin
            step_p1 <= step_p0;
            cnt_p1  <= (rep_count == '0) ? '0 : rep_count - CNT_W'(1);
        end else if ((state == ST_REP) && retire && !out_last) begin
            cnt_p1 <= cnt_p1 - CNT_W'(1);
        end
    end

endmodule
